// File: rtl/clk_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : clk_period_monitor
//  Description : Measures high/low widths of a divided clock in clk_in cycles,
//                checks them against expected widths, reports lock and errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_period_monitor #(
    parameter int CW     = 8,
    parameter int TOL    = 1,
    parameter int LOCK_N = 4
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    input  logic          sig_in,
    input  logic [CW-1:0] exp_high,
    input  logic [CW-1:0] exp_low,
    output logic [CW-1:0] high_len,
    output logic [CW-1:0] low_len,
    output logic          meas_valid,
    output logic          mismatch,
    output logic          err_sticky,
    output logic          locked,
    output logic [7:0]    period_cnt
);

    localparam int            c_GW      = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] c_MAX     = {CW{1'b1}};
    localparam logic [CW-1:0] c_ONE     = CW'(1);
    localparam logic [CW:0]   c_TOL     = (CW+1)'(TOL);
    localparam logic [c_GW-1:0] c_LOCK    = c_GW'(LOCK_N);
    localparam logic [c_GW-1:0] c_LOCK_M1 = c_GW'(LOCK_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_sig_s, r_sig_d;
    logic [1:0]      r_warm;
    logic [CW-1:0]   r_hcnt, r_lcnt;
    logic [c_GW-1:0] r_good_run;
    logic [CW-1:0]   r_high_len, r_low_len;
    logic            r_meas_valid, r_mismatch, r_err_sticky, r_locked;
    logic [7:0]      r_period_cnt;

    logic            w_edges_ok, w_rise, w_fall;
    logic            w_complete, w_timeout, w_good;
    logic signed [CW:0] w_dh, w_dl;
    logic [CW:0]     w_ah, w_al;

    // Edges seen during warm-up would compare against the reset value of the pipe.
    assign w_edges_ok = (r_warm == 2'd2);
    assign w_rise     = w_edges_ok &  r_sig_s & ~r_sig_d;
    assign w_fall     = w_edges_ok & ~r_sig_s &  r_sig_d;

    assign w_dh   = $signed({1'b0, r_hcnt}) - $signed({1'b0, exp_high});
    assign w_dl   = $signed({1'b0, r_lcnt}) - $signed({1'b0, exp_low});
    assign w_ah   = w_dh[CW] ? $unsigned(-w_dh) : $unsigned(w_dh);
    assign w_al   = w_dl[CW] ? $unsigned(-w_dl) : $unsigned(w_dl);
    assign w_good = (w_ah <= c_TOL) && (w_al <= c_TOL);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        if (!en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ARM;
                S_ARM: begin
                    if (w_rise) w_state_nxt = S_HIGH;
                end
                S_HIGH: begin
                    if (r_hcnt == c_MAX) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_ARM;
                    end else if (w_fall) begin
                        w_state_nxt = S_LOW;
                    end
                end
                S_LOW: begin
                    if (r_lcnt == c_MAX) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_ARM;
                    end else if (w_rise) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_HIGH;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_sig_s      <= 1'b0;
            r_sig_d      <= 1'b0;
            r_warm       <= 2'd0;
            r_hcnt       <= '0;
            r_lcnt       <= '0;
            r_good_run   <= '0;
            r_high_len   <= '0;
            r_low_len    <= '0;
            r_meas_valid <= 1'b0;
            r_mismatch   <= 1'b0;
            r_err_sticky <= 1'b0;
            r_locked     <= 1'b0;
            r_period_cnt <= 8'd0;
        end else begin
            r_sig_s      <= sig_in;
            r_sig_d      <= r_sig_s;
            if (!w_edges_ok) r_warm <= r_warm + 2'd1;
            r_meas_valid <= 1'b0;
            r_mismatch   <= 1'b0;

            if (r_state == S_IDLE) begin
                r_hcnt     <= '0;
                r_lcnt     <= '0;
                r_good_run <= '0;
                r_locked   <= 1'b0;
            end

            if (en && !w_timeout) begin
                case (r_state)
                    S_ARM: begin
                        if (w_rise) r_hcnt <= c_ONE;
                    end
                    S_HIGH: begin
                        if (w_fall) r_lcnt <= c_ONE;
                        else        r_hcnt <= r_hcnt + c_ONE;
                    end
                    S_LOW: begin
                        if (w_rise) r_hcnt <= c_ONE;
                        else        r_lcnt <= r_lcnt + c_ONE;
                    end
                    default: ;
                endcase
            end

            if (w_complete) begin
                r_high_len   <= r_hcnt;
                r_low_len    <= r_lcnt;
                r_meas_valid <= 1'b1;
                if (r_period_cnt != 8'hFF) r_period_cnt <= r_period_cnt + 8'd1;
                if (w_good) begin
                    if (r_good_run != c_LOCK) r_good_run <= r_good_run + 1'b1;
                    if (r_good_run >= c_LOCK_M1) r_locked <= 1'b1;
                end else begin
                    r_mismatch   <= 1'b1;
                    r_err_sticky <= 1'b1;
                    r_good_run   <= '0;
                    r_locked     <= 1'b0;
                end
            end

            if (w_timeout) begin
                r_mismatch   <= 1'b1;
                r_err_sticky <= 1'b1;
                r_good_run   <= '0;
                r_locked     <= 1'b0;
            end
        end
    end

    assign high_len   = r_high_len;
    assign low_len    = r_low_len;
    assign meas_valid = r_meas_valid;
    assign mismatch   = r_mismatch;
    assign err_sticky = r_err_sticky;
    assign locked     = r_locked;
    assign period_cnt = r_period_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_period_monitor
//  Description : Self-checking bench; timestamp-based reference model of the
//                period monitor compared against the DUT on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clk_period_monitor;

    localparam int CW     = 8;
    localparam int TOL    = 1;
    localparam int LOCK_N = 4;
    localparam int MAXC   = 255;

    logic          clk_in = 1'b0;
    logic          rst    = 1'b1;
    logic          en     = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] exp_high = '0;
    logic [CW-1:0] exp_low  = '0;
    logic [CW-1:0] high_len, low_len;
    logic          meas_valid, mismatch, err_sticky, locked;
    logic [7:0]    period_cnt;

    clk_period_monitor #(.CW(CW), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .exp_high   (exp_high),
        .exp_low    (exp_low),
        .high_len   (high_len),
        .low_len    (low_len),
        .meas_valid (meas_valid),
        .mismatch   (mismatch),
        .err_sticky (err_sticky),
        .locked     (locked),
        .period_cnt (period_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: widths are differences of edge timestamps (in clk_in edges).
    int   m_mode = 0;           // 0 idle, 1 armed, 2 in high phase, 3 in low phase
    int   t_now = 0, t_rise = 0, t_fall = 0, warm = 0, good_run = 0, m_pc = 0;
    logic s1 = 1'b0, s2 = 1'b0;
    logic [CW-1:0] m_high = '0, m_low = '0;
    logic m_mv = 1'b0, m_mm = 1'b0, m_err = 1'b0, m_locked = 1'b0;
    bit   model_ok = 1'b0;

    always @(posedge clk_in) begin : model
        bit rise, fall, bad;
        int h, l, dh, dl;
        t_now++;
        if (rst) begin
            m_mode = 0; warm = 0; good_run = 0; m_pc = 0;
            s1 = 1'b0; s2 = 1'b0;
            m_high = '0; m_low = '0;
            m_mv = 1'b0; m_mm = 1'b0; m_err = 1'b0; m_locked = 1'b0;
            model_ok = 1'b1;
        end else begin
            rise = (warm >= 2) && s1 && !s2;
            fall = (warm >= 2) && !s1 && s2;
            if (warm < 2) warm++;
            m_mv = 1'b0;
            m_mm = 1'b0;
            bad  = 1'b0;
            if (m_mode == 0) begin
                good_run = 0;
                m_locked = 1'b0;
            end
            if (!en) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (rise) begin m_mode = 2; t_rise = t_now; end
            end else if (m_mode == 2) begin
                if (t_now - t_rise == MAXC) begin bad = 1'b1; m_mode = 1; end
                else if (fall) begin m_mode = 3; t_fall = t_now; end
            end else begin
                if (t_now - t_fall == MAXC) begin bad = 1'b1; m_mode = 1; end
                else if (rise) begin
                    h = t_fall - t_rise;
                    l = t_now - t_fall;
                    m_high = CW'(h);
                    m_low  = CW'(l);
                    m_mv   = 1'b1;
                    if (m_pc < 255) m_pc++;
                    dh = h - int'(exp_high);
                    dl = l - int'(exp_low);
                    if (dh < 0) dh = -dh;
                    if (dl < 0) dl = -dl;
                    if (dh <= TOL && dl <= TOL) begin
                        if (good_run < LOCK_N) good_run++;
                        if (good_run >= LOCK_N) m_locked = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                    t_rise = t_now;
                    m_mode = 2;
                end
            end
            if (bad) begin
                m_mm = 1'b1; m_err = 1'b1; m_locked = 1'b0; good_run = 0;
            end
            s2 = s1;
            s1 = sig_in;
        end
    end

    always @(negedge clk_in) begin
        if (model_ok) begin
            n_cmp++;
            if ({high_len, low_len, meas_valid, mismatch, err_sticky, locked, period_cnt} !==
                {m_high, m_low, m_mv, m_mm, m_err, m_locked, 8'(m_pc)}) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got hl=%0d ll=%0d mv=%b mm=%b err=%b lk=%b pc=%0d required hl=%0d ll=%0d mv=%b mm=%b err=%b lk=%b pc=%0d",
                         $time, high_len, low_len, meas_valid, mismatch, err_sticky, locked, period_cnt,
                         m_high, m_low, m_mv, m_mm, m_err, m_locked, m_pc);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic drive(input int hi, input int lo, input int periods);
        for (int p = 0; p < periods; p++) begin
            sig_in = 1'b1; repeat (hi) @(negedge clk_in);
            sig_in = 1'b0; repeat (lo) @(negedge clk_in);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1; @(negedge clk_in); rst = 1'b0;
    endtask

    initial begin
        int hi, lo, np, eh, el;
        repeat (3) @(negedge clk_in);
        chk("reset_pc", period_cnt, 0);
        chk("reset_err", err_sticky, 0);
        chk("reset_locked", locked, 0);
        chk("reset_mv", meas_valid, 0);

        // div-2
        rst = 1'b0; en = 1'b1; exp_high = 8'd1; exp_low = 8'd1;
        drive(1, 1, 12);
        chk("div2_high", high_len, 1);
        chk("div2_low", low_len, 1);
        chk("div2_locked", locked, 1);
        chk("div2_err", err_sticky, 0);

        // div-26, then wrong expected high width
        exp_high = 8'd13; exp_low = 8'd13;
        drive(13, 13, 6);
        chk("div26_high", high_len, 13);
        chk("div26_low", low_len, 13);
        chk("div26_locked", locked, 1);
        exp_high = 8'd11;
        drive(13, 13, 3);
        chk("div26_bad_locked", locked, 0);
        chk("div26_bad_err", err_sticky, 1);

        // reset mid-low with sticky error set
        sig_in = 1'b1; repeat (13) @(negedge clk_in);
        sig_in = 1'b0; repeat (5) @(negedge clk_in);
        rst = 1'b1; @(negedge clk_in);
        chk("rst_mid_pc", period_cnt, 0);
        chk("rst_mid_err", err_sticky, 0);
        chk("rst_mid_high", high_len, 0);
        rst = 1'b0;

        // 2-high / 3-low
        exp_high = 8'd2; exp_low = 8'd3;
        drive(2, 3, 8);
        chk("p23_locked", locked, 1);
        chk("p23_err", err_sticky, 0);
        chk("p23_low", low_len, 3);
        exp_high = 8'd4; exp_low = 8'd1;
        drive(2, 3, 3);
        chk("p23_bad_err", err_sticky, 1);
        chk("p23_bad_locked", locked, 0);

        // timeout while high
        pulse_rst();
        exp_high = 8'd13; exp_low = 8'd13;
        sig_in = 1'b0; repeat (4) @(negedge clk_in);
        sig_in = 1'b1; repeat (300) @(negedge clk_in);
        chk("timeout_err", err_sticky, 1);
        chk("timeout_pc", period_cnt, 0);
        sig_in = 1'b0; repeat (4) @(negedge clk_in);

        // en dropped mid-high
        pulse_rst();
        exp_high = 8'd5; exp_low = 8'd5;
        drive(5, 5, 6);
        sig_in = 1'b1; repeat (3) @(negedge clk_in);
        en = 1'b0; repeat (2) @(negedge clk_in);
        en = 1'b1; repeat (2) @(negedge clk_in);
        drive(5, 5, 4);
        chk("en_drop_err", err_sticky, 0);

        // randomized traffic
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 99) < 4) pulse_rst();
            if ($urandom_range(0, 99) < 10) begin
                en = 1'b0; repeat ($urandom_range(1, 5)) @(negedge clk_in); en = 1'b1;
            end
            hi = $urandom_range(1, 16);
            lo = $urandom_range(1, 16);
            if ($urandom_range(0, 99) < 2) hi = $urandom_range(250, 270);
            np = $urandom_range(1, 4);
            eh = hi + int'($urandom_range(0, 4)) - 2;
            el = lo + int'($urandom_range(0, 4)) - 2;
            if (eh < 0) eh = 0;
            if (el < 0) el = 0;
            if (eh > 255) eh = 255;
            exp_high = CW'(eh);
            exp_low  = CW'(el);
            drive(hi, lo, np);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
